psum_adder_accum: RTL and testbench
===================================

Name: psum_adder_accum

Overview:
- Clocked partial-sum adder directly downstream of the adder-side depacketizer.
- Receives psums on three per-PE lanes: lane0 = PE0 queue (source 3), lane1 = PE1 queue (source 1), lane2 = PE2 queue (source 0).
- Buffers each lane in its own FIFO, pops one psum from every lane at once, and sums the three.
- Accumulates over PASSES rounds, then emits one result packet to the output-memory/packetizer stage.

Parameters:
- DWIDTH, 8, psum data width per lane and in the packet.
- PWIDTH, 47, output packet width.
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
- PASSES, 1, number of 3-lane rounds accumulated per output result; minimum 1.
- SRC_ADDR, 3'd5, value placed in the packet source field.
- DST_ADDR, 3'd7, value placed in the packet destination field.
- SATURATE, 0, 1 = clamp result to 2^DWIDTH-1; 0 = truncate to DWIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in0_data  in  DWIDTH  lane0 psum.
- in0_valid  in  1  lane0 data valid.
- in0_ready  out  1  lane0 FIFO can accept.
- in1_data / in1_valid / in1_ready  as lane0, for lane1.
- in2_data / in2_valid / in2_ready  as lane0, for lane2.
- out_packet  out  PWIDTH  result packet.
- out_valid  out  1  out_packet valid.
- out_ready  in  1  consumer accepts.
- busy  out  1  accumulation in progress: pass_cnt != 0 or in SEND.

Behaviour:
- Reset (async, immediate):
  - all FIFOs empty; pass_cnt = 0; acc = 0; state = COLLECT.
  - out_valid = 0; out_packet = 0; busy = 0.
  - inN_ready = 1 after reset deasserts.
  - Reset mid-operation discards buffered psums and any partial or pending result.
- Lane FIFO:
  - inN_ready = !full.
  - A push occurs at an edge where valid && ready.
  - When full, ready is low even if a pop happens in the same cycle; there is no pass-through.
  - A push becomes visible (non-empty) the cycle after the edge.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter distinguishes full from empty.
- Internal arithmetic:
  - Accumulator width AW = DWIDTH+2+clog2(PASSES+1), so it never overflows internally.
  - Operands are unsigned.
- FSM state COLLECT:
  - If all three FIFOs are non-empty: pop all three at this edge, acc <= (pass_cnt==0 ? 0 : acc) + d0 + d1 + d2.
  - If pass_cnt == PASSES-1: pass_cnt <= 0 and go to SEND. Otherwise pass_cnt++.
  - If any lane is empty: no pop; other lanes keep filling.
- FSM state SEND:
  - out_valid = 1.
  - out_packet is stable until accepted and is built from registered acc.
  - At an edge with out_ready: out_valid drops and state returns to COLLECT.
  - No pops occur in SEND; lanes continue to accept data until full.
- Packet format:
  - [DWIDTH-1:0] = result.
  - [42:40] = SRC_ADDR.
  - [45:43] = DST_ADDR.
  - All other bits 0.
- Result value:
  - SATURATE=1: min(acc, 2^DWIDTH-1).
  - SATURATE=0: acc[DWIDTH-1:0].
- Latency (PASSES=1, out_ready held high):
  - Last lane pushed at edge k, pop/add at edge k+1, out_valid high in the cycle after edge k+1, accepted at edge k+2.
  - Peak throughput is one result per 2 cycles.
- Simultaneous events:
  - A push to a lane at the same edge as a pop of that lane is legal when not full; occupancy is unchanged.
  - Lanes arriving in different cycles are aligned purely by FIFO order.

Decomposition:
- Shared package psum_adder_pkg holds:
  - field constants SRC_LSB=40, DST_LSB=43, ADDR_W=3;
  - state enum {COLLECT, SEND};
  - a function building the output packet from result, src and dst.
- One sub-module, psum_lane_fifo (DWIDTH, FIFO_DEPTH), with push/pop/full/empty/dout, instantiated three times.
- FSM, accumulator and packet formatting live in the top.

Test Plan:
- Reset then single round, PASSES=1: lanes get 10, 20, 30 in one cycle -> one packet, data=60, [42:40]=5, [45:43]=7, out_valid the cycle after the pop.
- Skewed arrival: lane0=1 at cycle 0, lane1=2 at cycle 3, lane2=3 at cycle 7 -> no output before lane2 is visible; then data=6; FIFOs empty after.
- Saturation vs wrap with 200, 100, 50:
  - SATURATE=1 -> 255;
  - SATURATE=0 -> 350 mod 256 = 94.
- PASSES=3 with rounds (1,1,1), (2,2,2), (3,3,3) -> exactly one packet, data=18; busy high from the first pop until accepted.
- Backpressure with out_ready=0 for 10 cycles while each lane receives 5 psums (depth 4):
  - each inN_ready drops after 4 pushes;
  - out_packet is held stable;
  - after release, results emerge in FIFO order with no loss.
- Async reset asserted mid-SEND and mid-fill -> out_valid=0 immediately without a clock edge; FIFOs empty; the next clean round of 4, 5, 6 yields 15.

Source files
------------

// File: rtl/psum_adder_pkg.sv
// Shared types, packet field positions and the packet builder for the
// three-lane partial-sum adder.
package psum_adder_pkg;

  localparam int SRC_LSB = 40;
  localparam int DST_LSB = 43;
  localparam int ADDR_W  = 3;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  // Result occupies the low bits, routing fields sit at fixed offsets,
  // every other bit stays zero.
  function automatic logic [63:0] build_packet(input logic [63:0]       result,
                                               input logic [ADDR_W-1:0] src,
                                               input logic [ADDR_W-1:0] dst);
    logic [63:0] p;
    p = result;
    p[SRC_LSB +: ADDR_W] = src;
    p[DST_LSB +: ADDR_W] = dst;
    return p;
  endfunction

endpackage

// File: rtl/psum_adder_accum_if.sv
// Lane inputs, result output and status of the partial-sum adder.
// Handshake: a beat transfers at a rising clk edge where valid && ready are both
// high; the sender holds data stable while valid is high and ready is low.
interface psum_adder_accum_if #(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 47
);

  logic [DWIDTH-1:0]      in0_data;
  logic                   in0_valid;
  logic                   in0_ready;
  logic [DWIDTH-1:0]      in1_data;
  logic                   in1_valid;
  logic                   in1_ready;
  logic [DWIDTH-1:0]      in2_data;
  logic                   in2_valid;
  logic                   in2_ready;
  logic [PWIDTH-1:0]      out_packet;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  psum_adder_pkg::state_t state;

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, in2_data, in2_valid, out_ready,
    input  in0_ready, in1_ready, in2_ready, out_packet, out_valid, busy, state
  );

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, in2_data, in2_valid, out_ready,
    output in0_ready, in1_ready, in2_ready, out_packet, out_valid, busy, state
  );

endinterface

// File: rtl/psum_lane_fifo.sv
// Single-lane psum FIFO; an occupancy counter separates full from empty
// because the pointers alone wrap to the same value in both cases.
module psum_lane_fifo #(
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DWIDTH-1:0] dout
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage needs no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_adder_accum.sv
// Three-lane partial-sum adder: buffers each lane, sums one psum per lane per
// round, accumulates PASSES rounds and emits one result packet.
module psum_adder_accum
  import psum_adder_pkg::*;
#(
  parameter int         DWIDTH     = 8,
  parameter int         PWIDTH     = 47,
  parameter int         FIFO_DEPTH = 4,
  parameter int         PASSES     = 1,
  parameter logic [2:0] SRC_ADDR   = 3'd5,
  parameter logic [2:0] DST_ADDR   = 3'd7,
  parameter int         SATURATE   = 0
) (
  input logic               clk,
  input logic               rst,
  psum_adder_accum_if.slave bus
);

  localparam int CW = $clog2(PASSES + 1);
  localparam int AW = DWIDTH + 2 + CW;

  logic [DWIDTH-1:0] lane_data [3];
  logic [DWIDTH-1:0] lane_dout [3];
  logic [2:0]        lane_valid;
  logic [2:0]        lane_full;
  logic [2:0]        lane_empty;
  logic [2:0]        lane_push;
  logic              pop;

  state_t            state;
  logic [CW-1:0]     pass_cnt;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_next;
  logic [DWIDTH-1:0] result;
  logic              last_pass;
  logic              out_valid;
  logic [PWIDTH-1:0] out_packet;

  assign lane_data[0] = bus.in0_data;
  assign lane_data[1] = bus.in1_data;
  assign lane_data[2] = bus.in2_data;
  assign lane_valid   = {bus.in2_valid, bus.in1_valid, bus.in0_valid};

  // Ready depends only on full, so a full lane stays closed even while popping.
  assign bus.in0_ready = !lane_full[0];
  assign bus.in1_ready = !lane_full[1];
  assign bus.in2_ready = !lane_full[2];
  assign lane_push     = lane_valid & ~lane_full;

  assign pop = (state == COLLECT) && (lane_empty == 3'b000);

  for (genvar g = 0; g < 3; g++) begin : g_lane
    psum_lane_fifo #(
      .DWIDTH     (DWIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (lane_push[g]),
      .pop   (pop),
      .din   (lane_data[g]),
      .full  (lane_full[g]),
      .empty (lane_empty[g]),
      .dout  (lane_dout[g])
    );
  end

  assign last_pass = (pass_cnt == CW'(PASSES - 1));
  assign acc_next  = ((pass_cnt == '0) ? '0 : acc) + AW'(lane_dout[0])
                   + AW'(lane_dout[1]) + AW'(lane_dout[2]);

  always_comb begin
    result = acc_next[DWIDTH-1:0];
    if ((SATURATE != 0) && (|acc_next[AW-1:DWIDTH])) begin
      result = '1;
    end
  end

  // The packet is captured once on entry to SEND and then held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      pass_cnt   <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_packet <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (pop) begin
            acc <= acc_next;
            if (last_pass) begin
              pass_cnt   <= '0;
              state      <= SEND;
              out_valid  <= 1'b1;
              out_packet <= PWIDTH'(build_packet(64'(result), SRC_ADDR, DST_ADDR));
            end else begin
              pass_cnt <= pass_cnt + CW'(1);
            end
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_packet = out_packet;
  assign bus.busy       = (pass_cnt != '0) || (state == SEND);
  assign bus.state      = state;

endmodule

// File: tb/tb_psum_adder_accum.sv
// Directed bench for psum_adder_accum: wrap, saturating and three-pass
// instances share one stimulus bus, gated per instance by an enable.
module tb_psum_adder_accum;
  import psum_adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic       out_ready = 1'b1;
  logic       en_a = 1'b0, en_s = 1'b0, en_p = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] d0, d1, d2;
    logic [7:0] exp_w;
    logic [7:0] exp_s;
  } vec_t;
  vec_t vecs[6];

  psum_adder_accum_if #(.DWIDTH(8), .PWIDTH(47)) if_a ();
  psum_adder_accum_if #(.DWIDTH(8), .PWIDTH(47)) if_s ();
  psum_adder_accum_if #(.DWIDTH(8), .PWIDTH(47)) if_p ();

  assign if_a.in0_data = d0;  assign if_a.in1_data = d1;  assign if_a.in2_data = d2;
  assign if_a.in0_valid = v0 & en_a;  assign if_a.in1_valid = v1 & en_a;
  assign if_a.in2_valid = v2 & en_a;  assign if_a.out_ready = out_ready;
  assign if_s.in0_data = d0;  assign if_s.in1_data = d1;  assign if_s.in2_data = d2;
  assign if_s.in0_valid = v0 & en_s;  assign if_s.in1_valid = v1 & en_s;
  assign if_s.in2_valid = v2 & en_s;  assign if_s.out_ready = out_ready;
  assign if_p.in0_data = d0;  assign if_p.in1_data = d1;  assign if_p.in2_data = d2;
  assign if_p.in0_valid = v0 & en_p;  assign if_p.in1_valid = v1 & en_p;
  assign if_p.in2_valid = v2 & en_p;  assign if_p.out_ready = out_ready;

  psum_adder_accum #(.PASSES(1), .SATURATE(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  psum_adder_accum #(.PASSES(1), .SATURATE(1)) dut_s (.clk(clk), .rst(rst), .bus(if_s.slave));
  psum_adder_accum #(.PASSES(3), .SATURATE(0)) dut_p (.clk(clk), .rst(rst), .bus(if_p.slave));

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] mk_pkt(input logic [7:0] d);
    logic [63:0] p;
    p        = '0;
    p[7:0]   = d;
    p[42:40] = 3'd5;
    p[45:43] = 3'd7;
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks: all driving happens at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [2:0] lanes);
    d0 = a;  d1 = b;  d2 = c;
    v0 = lanes[0];  v1 = lanes[1];  v2 = lanes[2];
    @(negedge clk);
    v0 = 1'b0;  v1 = 1'b0;  v2 = 1'b0;
  endtask

  function automatic logic [2:0] readys_a();
    return {if_a.in2_ready, if_a.in1_ready, if_a.in0_ready};
  endfunction

  initial begin
    logic pending;
    logic drove;

    vecs[0] = '{10,  20,  30,  60,  60};
    vecs[1] = '{200, 100, 50,  94,  255};
    vecs[2] = '{255, 255, 255, 253, 255};
    vecs[3] = '{0,   0,   0,   0,   0};
    vecs[4] = '{100, 100, 55,  255, 255};
    vecs[5] = '{100, 100, 56,  0,   255};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 64'(if_a.out_valid), 0);
    check("rst_packet", 64'(if_a.out_packet), 0);
    check("rst_busy", 64'(if_a.busy), 0);
    check("rst_ready", 64'(readys_a()), 7);
    check("rst_state", 64'(if_a.state), 64'(COLLECT));
    check("rst_p_busy", 64'(if_p.busy), 0);

    // Single rounds: wrap and saturate instances in lockstep
    en_a = 1'b1;
    en_s = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].d0, vecs[i].d1, vecs[i].d2, 3'b111);
      check("vec_early_valid", 64'(if_a.out_valid), 0);
      tick();
      check("vec_valid", 64'(if_a.out_valid), 1);
      check("vec_busy", 64'(if_a.busy), 1);
      check("vec_wrap_pkt", 64'(if_a.out_packet), mk_pkt(vecs[i].exp_w));
      check("vec_sat_pkt", 64'(if_s.out_packet), mk_pkt(vecs[i].exp_s));
      tick();
      check("vec_accepted", 64'(if_a.out_valid), 0);
      check("vec_idle", 64'(if_a.busy), 0);
    end
    en_s = 1'b0;

    // Skewed arrival: aligned only by FIFO order
    push(1, 0, 0, 3'b001);
    for (int i = 0; i < 2; i++) begin
      check("skew_wait0", 64'(if_a.out_valid), 0);
      tick();
    end
    push(0, 2, 0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      check("skew_wait1", 64'(if_a.out_valid), 0);
      tick();
    end
    push(0, 0, 3, 3'b100);
    check("skew_not_yet", 64'(if_a.out_valid), 0);
    tick();
    check("skew_valid", 64'(if_a.out_valid), 1);
    check("skew_pkt", 64'(if_a.out_packet), mk_pkt(8'd6));
    tick();
    tick();
    check("skew_drained", 64'(if_a.out_valid), 0);

    // Three-pass accumulation
    en_a = 1'b0;
    en_p = 1'b1;
    out_ready = 1'b0;
    push(1, 1, 1, 3'b111);
    check("p_busy_prepop", 64'(if_p.busy), 0);
    tick();
    check("p_busy_r1", 64'(if_p.busy), 1);
    check("p_valid_r1", 64'(if_p.out_valid), 0);
    push(2, 2, 2, 3'b111);
    tick();
    check("p_busy_r2", 64'(if_p.busy), 1);
    check("p_valid_r2", 64'(if_p.out_valid), 0);
    push(3, 3, 3, 3'b111);
    tick();
    check("p_valid_r3", 64'(if_p.out_valid), 1);
    check("p_pkt", 64'(if_p.out_packet), mk_pkt(8'd18));
    check("p_busy_send", 64'(if_p.busy), 1);
    tick();
    check("p_hold_pkt", 64'(if_p.out_packet), mk_pkt(8'd18));
    out_ready = 1'b1;
    tick();
    check("p_accepted", 64'(if_p.out_valid), 0);
    check("p_busy_done", 64'(if_p.busy), 0);
    en_p = 1'b0;

    // Backpressure: stall in SEND while lanes fill
    en_a = 1'b1;
    out_ready = 1'b0;
    push(7, 8, 9, 3'b111);
    tick();
    check("bp_first_valid", 64'(if_a.out_valid), 1);
    check("bp_first_pkt", 64'(if_a.out_packet), mk_pkt(8'd24));
    for (int i = 0; i < 4; i++) begin
      check("bp_ready_open", 64'(readys_a()), 7);
      push(8'(10 + i), 8'(20 + i), 8'(30 + i), 3'b111);
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_ready_full", 64'(readys_a()), 0);
      check("bp_hold_pkt", 64'(if_a.out_packet), mk_pkt(8'd24));
      tick();
    end
    exp_q = {8'd24, 8'd60, 8'd63, 8'd66, 8'd69, 8'd72};
    pending = 1'b1;
    drove = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (drove) begin
        v0 = 1'b0;  v1 = 1'b0;  v2 = 1'b0;
        drove = 1'b0;
      end
      if (if_a.out_valid) begin
        if (exp_q.size() == 0) begin
          check("bp_extra_pkt", 64'(if_a.out_packet), 0);
        end else begin
          check("bp_order_pkt", 64'(if_a.out_packet), mk_pkt(exp_q.pop_front()));
        end
      end
      if (pending && (readys_a() == 3'b111)) begin
        d0 = 8'd14;  d1 = 8'd24;  d2 = 8'd34;
        v0 = 1'b1;  v1 = 1'b1;  v2 = 1'b1;
        drove = 1'b1;
        pending = 1'b0;
      end
      if ((exp_q.size() == 0) && !pending && !drove) break;
      tick();
    end
    check("bp_remaining", 64'(exp_q.size()), 0);
    tick();
    tick();
    check("bp_idle_valid", 64'(if_a.out_valid), 0);
    check("bp_idle_busy", 64'(if_a.busy), 0);

    // Asynchronous reset mid-SEND with a partially filled lane
    out_ready = 1'b0;
    push(1, 2, 3, 3'b111);
    tick();
    check("ar_send_valid", 64'(if_a.out_valid), 1);
    push(9, 0, 0, 3'b001);
    #2 rst = 1'b1;
    #1;
    check("ar_valid_now", 64'(if_a.out_valid), 0);
    check("ar_packet_now", 64'(if_a.out_packet), 0);
    check("ar_busy_now", 64'(if_a.busy), 0);
    check("ar_ready_now", 64'(readys_a()), 7);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    push(4, 5, 6, 3'b111);
    check("ar_clean_early", 64'(if_a.out_valid), 0);
    tick();
    check("ar_clean_valid", 64'(if_a.out_valid), 1);
    check("ar_clean_pkt", 64'(if_a.out_packet), mk_pkt(8'd15));
    tick();
    check("ar_clean_done", 64'(if_a.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
